// File: rtl/pll_reset_seq.sv
// Reset sequencer behind sys_pll: pulses the PLL reset, waits for stable lock, then releases
// the memory, system and video domain resets in order. Re-arms on lock loss or lock timeout.
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES     = 4,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int RELOCK_TIMEOUT     = 1048576,
    parameter int CNT_W              = 21
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       mem_ready,
    output logic       pll_rst,
    output logic       mem_rst,
    output logic       sys_rst,
    output logic       vid_rst,
    output logic       ready,
    output logic [7:0] lock_loss_cnt
);

    localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 64'sd1;

    if (longint'(PLL_RST_CYCLES) > CNT_MAX || longint'(LOCK_STABLE_CYCLES) > CNT_MAX ||
        longint'(STAGE_GAP) > CNT_MAX || longint'(RELOCK_TIMEOUT) > CNT_MAX) begin : g_param_err
        $error("pll_reset_seq: cycle parameter does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(RELOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_PLLRST, S_WAITLOCK, S_STABLE, S_MEM, S_SYS, S_VID, S_RUN
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             locked_s1, locked_s, ready_s1, ready_s;
    logic             lock_loss;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_s1 <= 1'b0;
            locked_s  <= 1'b0;
            ready_s1  <= 1'b0;
            ready_s   <= 1'b0;
        end else begin
            locked_s1 <= pll_locked;
            locked_s  <= locked_s1;
            ready_s1  <= mem_ready;
            ready_s   <= ready_s1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        lock_loss = 1'b0;
        case (state)
            S_PLLRST:
                if (cnt == PLL_LAST) begin
                    state_nxt = S_WAITLOCK;
                    cnt_nxt   = '0;
                end
            S_WAITLOCK:
                if (locked_s) begin
                    state_nxt = S_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = S_PLLRST;
                    cnt_nxt   = '0;
                end
            S_STABLE:
                if (!locked_s) begin
                    state_nxt = S_WAITLOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = S_MEM;
                    cnt_nxt   = '0;
                end
            S_MEM:
                if (ready_s && cnt >= GAP_LAST) begin
                    state_nxt = S_SYS;
                    cnt_nxt   = '0;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = S_PLLRST;
                    cnt_nxt   = '0;
                end
            S_SYS:
                if (cnt == GAP_LAST) begin
                    state_nxt = S_VID;
                    cnt_nxt   = '0;
                end
            S_VID:
                if (cnt == GAP_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end
            S_RUN:
                cnt_nxt = cnt;
            default: begin
                state_nxt = S_PLLRST;
                cnt_nxt   = '0;
            end
        endcase
        // Lock loss after the first release overrides any stage advance above.
        if (state inside {S_MEM, S_SYS, S_VID, S_RUN} && !locked_s) begin
            state_nxt = S_WAITLOCK;
            cnt_nxt   = '0;
            lock_loss = 1'b1;
        end
    end

    // Outputs decode the next state so they switch on the same edge as the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state         <= S_PLLRST;
            cnt           <= '0;
            pll_rst       <= 1'b1;
            mem_rst       <= 1'b1;
            sys_rst       <= 1'b1;
            vid_rst       <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pll_rst <= (state_nxt == S_PLLRST);
            mem_rst <= (state_nxt inside {S_PLLRST, S_WAITLOCK, S_STABLE});
            sys_rst <= !(state_nxt inside {S_SYS, S_VID, S_RUN});
            vid_rst <= !(state_nxt inside {S_VID, S_RUN});
            ready   <= (state_nxt == S_RUN);
            if (lock_loss && lock_loss_cnt != 8'hFF)
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end
    end

endmodule
